lcd_cmd_ctrl: RTL and testbench

- Consumer side of the CPU LCD output register (`o_io_lcd` from the LSU).
- Turns each software request written to that register into a correctly timed HD44780-style 8-bit write cycle on the physical LCD pins.
- Runs the LCD power-on initialization sequence autonomously after reset.
- Returns a status word (busy, init_done, ACK) that the LSU maps into a readable address, so firmware polls a handshake instead of bit-banging timing.

---
 rtl/lcd_cmd_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_lcd_cmd_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_cmd_ctrl.sv
// HD44780-style 8-bit write controller: runs the LCD power-on init sequence, then
// turns each REQ toggle in the LSU LCD register into one timed EN write cycle.
module lcd_cmd_ctrl #(
    parameter int unsigned POWERON_CYC  = 750000,
    parameter int unsigned SETUP_CYC    = 2,
    parameter int unsigned EN_HIGH_CYC  = 25,
    parameter int unsigned HOLD_CYC     = 2,
    parameter int unsigned EXEC_CYC     = 2000,
    parameter int unsigned CLR_EXEC_CYC = 82000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_lcd_reg,
    output logic [31:0] o_lcd_status,
    output logic [7:0]  o_lcd_data,
    output logic        o_lcd_rs,
    output logic        o_lcd_rw,
    output logic        o_lcd_en,
    output logic        o_lcd_on
);

    typedef enum logic [2:0] {
        PWR_WAIT,
        IDLE,
        SETUP,
        PULSE,
        HOLD,
        EXEC
    } state_t;

    localparam logic [31:0] PWR_LD   = 32'(POWERON_CYC - 1);
    localparam logic [31:0] SETUP_LD = 32'(SETUP_CYC - 1);
    localparam logic [31:0] EN_LD    = 32'(EN_HIGH_CYC - 1);
    localparam logic [31:0] HOLD_LD  = 32'(HOLD_CYC - 1);
    localparam logic [31:0] EXEC_LD  = 32'(EXEC_CYC - 1);
    localparam logic [31:0] CLR_LD   = 32'(CLR_EXEC_CYC - 1);

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [2:0]  init_idx_q, init_idx_d;
    logic        init_done_q, init_done_d;
    logic        ack_q, ack_d;
    logic        req_q, req_d;
    logic [7:0]  data_q, data_d;
    logic        rs_q, rs_d;
    logic        en_q, en_d;
    logic        on_q, on_d;
    logic        is_clr;
    logic        busy;
    logic        unused_bits;

    function automatic logic [7:0] init_cmd(input logic [2:0] idx);
        logic [7:0] cmd;
        case (idx)
            3'd0, 3'd1, 3'd2: cmd = 8'h38;
            3'd3:             cmd = 8'h0C;
            3'd4:             cmd = 8'h01;
            default:          cmd = 8'h06;
        endcase
        return cmd;
    endfunction

    // Clear and home commands need the long execution wait.
    assign is_clr = !rs_q && (data_q == 8'h01 || data_q == 8'h02 || data_q == 8'h03);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        init_idx_d  = init_idx_q;
        init_done_d = init_done_q;
        ack_d       = ack_q;
        req_d       = req_q;
        data_d      = data_q;
        rs_d        = rs_q;
        on_d        = i_lcd_reg[31];
        case (state_q)
            PWR_WAIT: begin
                if (cnt_q == 32'd0) begin
                    state_d    = SETUP;
                    cnt_d      = SETUP_LD;
                    init_idx_d = 3'd0;
                    data_d     = init_cmd(3'd0);
                    rs_d       = 1'b0;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            IDLE: begin
                if (init_done_q && (i_lcd_reg[30] != ack_q)) begin
                    state_d = SETUP;
                    cnt_d   = SETUP_LD;
                    data_d  = i_lcd_reg[7:0];
                    rs_d    = i_lcd_reg[8];
                    req_d   = i_lcd_reg[30];
                end
            end
            SETUP: begin
                if (cnt_q == 32'd0) begin
                    state_d = PULSE;
                    cnt_d   = EN_LD;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            PULSE: begin
                if (cnt_q == 32'd0) begin
                    state_d = HOLD;
                    cnt_d   = HOLD_LD;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            HOLD: begin
                if (cnt_q == 32'd0) begin
                    state_d = EXEC;
                    cnt_d   = is_clr ? CLR_LD : EXEC_LD;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            EXEC: begin
                if (cnt_q == 32'd0) begin
                    if (!init_done_q) begin
                        if (init_idx_q < 3'd5) begin
                            state_d    = SETUP;
                            cnt_d      = SETUP_LD;
                            init_idx_d = init_idx_q + 3'd1;
                            data_d     = init_cmd(init_idx_q + 3'd1);
                            rs_d       = 1'b0;
                        end else begin
                            state_d     = IDLE;
                            init_done_d = 1'b1;
                        end
                    end else begin
                        state_d = IDLE;
                        ack_d   = req_q;
                    end
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            default: begin
                state_d = PWR_WAIT;
                cnt_d   = PWR_LD;
            end
        endcase
        en_d = (state_d == PULSE);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= PWR_WAIT;
            cnt_q       <= PWR_LD;
            init_idx_q  <= 3'd0;
            init_done_q <= 1'b0;
            ack_q       <= 1'b0;
            req_q       <= 1'b0;
            data_q      <= 8'd0;
            rs_q        <= 1'b0;
            en_q        <= 1'b0;
            on_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            init_idx_q  <= init_idx_d;
            init_done_q <= init_done_d;
            ack_q       <= ack_d;
            req_q       <= req_d;
            data_q      <= data_d;
            rs_q        <= rs_d;
            en_q        <= en_d;
            on_q        <= on_d;
        end
    end

    // Busy must read 1 during reset even before the state register settles.
    assign busy         = i_reset || (state_q != IDLE);
    assign o_lcd_status = {1'b0, ack_q, 28'd0, init_done_q, busy};
    assign o_lcd_data   = data_q;
    assign o_lcd_rs     = rs_q;
    assign o_lcd_rw     = 1'b0;
    assign o_lcd_en     = en_q;
    assign o_lcd_on     = on_q;
    assign unused_bits  = ^i_lcd_reg[29:9];

endmodule

// File: tb/tb_lcd_cmd_ctrl.sv
// Self-checking bench for lcd_cmd_ctrl: init sequence timing, randomized user writes,
// pending requests across reset/init, pin stability and mid-transfer reset.
module tb_lcd_cmd_ctrl;

    localparam int P_PWR   = 20;
    localparam int P_SETUP = 2;
    localparam int P_EN    = 4;
    localparam int P_HOLD  = 1;
    localparam int P_EXEC  = 10;
    localparam int P_CLR   = 40;
    localparam int BOUND   = 200;

    logic        clk;
    logic        i_reset;
    logic [31:0] i_lcd_reg;
    logic [31:0] o_lcd_status;
    logic [7:0]  o_lcd_data;
    logic        o_lcd_rs;
    logic        o_lcd_rw;
    logic        o_lcd_en;
    logic        o_lcd_on;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    logic req_model = 1'b0;

    lcd_cmd_ctrl #(
        .POWERON_CYC (P_PWR),
        .SETUP_CYC   (P_SETUP),
        .EN_HIGH_CYC (P_EN),
        .HOLD_CYC    (P_HOLD),
        .EXEC_CYC    (P_EXEC),
        .CLR_EXEC_CYC(P_CLR)
    ) dut (
        .i_clk       (clk),
        .i_reset     (i_reset),
        .i_lcd_reg   (i_lcd_reg),
        .o_lcd_status(o_lcd_status),
        .o_lcd_data  (o_lcd_data),
        .o_lcd_rs    (o_lcd_rs),
        .o_lcd_rw    (o_lcd_rw),
        .o_lcd_en    (o_lcd_en),
        .o_lcd_on    (o_lcd_on)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    function automatic int exec_of(input logic rs, input logic [7:0] d);
        return (!rs && d >= 8'h01 && d <= 8'h03) ? P_CLR : P_EXEC;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Counts consecutive negedge samples (current one included) where EN equals level.
    task automatic run_len(input logic level, output int n);
        n = 0;
        while (o_lcd_en === level && n < BOUND) begin
            n++;
            @(negedge clk);
        end
    endtask

    // Counts samples until status[idx] equals val.
    task automatic wait_bit(input int idx, input logic val, output int n);
        n = 0;
        while (o_lcd_status[idx] !== val && n < BOUND) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic check_init();
        logic [7:0] cmds [6];
        int n;
        cmds = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
        chk("pwr_busy", 32'(o_lcd_status[0]), 32'd1);
        chk("pwr_done", 32'(o_lcd_status[1]), 32'd0);
        chk("pwr_en", 32'(o_lcd_en), 32'd0);
        run_len(1'b0, n);
        chk("pwr_low_len", n, P_PWR + P_SETUP);
        for (int i = 0; i < 6; i++) begin
            chk("init_data", 32'(o_lcd_data), 32'(cmds[i]));
            chk("init_rs", 32'(o_lcd_rs), 32'd0);
            chk("init_done_low", 32'(o_lcd_status[1]), 32'd0);
            run_len(1'b1, n);
            chk("init_en_len", n, P_EN);
            if (i < 5) begin
                run_len(1'b0, n);
                chk("init_gap", n, P_HOLD + exec_of(1'b0, cmds[i]) + P_SETUP);
            end else begin
                wait_bit(1, 1'b1, n);
                chk("init_tail", n, P_HOLD + exec_of(1'b0, cmds[i]));
            end
        end
        chk("init_busy", 32'(o_lcd_status[0]), 32'd0);
        chk("init_ack", 32'(o_lcd_status[30]), 32'd0);
        $display("init sequence checked at cycle %0d", cyc);
    endtask

    // Starts at the IDLE sample in which the toggled register value is already applied.
    task automatic follow(input logic [31:0] val, input logic corrupt);
        int t0;
        int n;
        int x;
        t0 = cyc;
        x  = exec_of(val[8], val[7:0]);
        @(negedge clk);
        chk("xfer_data", 32'(o_lcd_data), 32'(val[7:0]));
        chk("xfer_rs", 32'(o_lcd_rs), 32'(val[8]));
        chk("xfer_on", 32'(o_lcd_on), 32'(val[31]));
        chk("xfer_busy", 32'(o_lcd_status[0]), 32'd1);
        run_len(1'b0, n);
        chk("xfer_setup_len", n, P_SETUP);
        if (corrupt) i_lcd_reg[7:0] = (val[7:0] == 8'h5A) ? 8'hA5 : 8'h5A;
        run_len(1'b1, n);
        chk("xfer_en_len", n, P_EN);
        chk("xfer_data_hold", 32'(o_lcd_data), 32'(val[7:0]));
        wait_bit(30, val[30], n);
        chk("xfer_exec_len", n, P_HOLD + x);
        chk("xfer_latency", cyc - t0, 1 + P_SETUP + P_EN + P_HOLD + x);
        chk("xfer_idle", 32'(o_lcd_status[0]), 32'd0);
        chk("xfer_data_end", 32'(o_lcd_data), 32'(val[7:0]));
        $display("xfer reg=%h data=%h rs=%0d exec=%0d latency=%0d", val, val[7:0], val[8], x, cyc - t0);
    endtask

    function automatic logic [31:0] mk(input logic on, input logic req, input logic rs,
                                       input logic [7:0] d, input logic [20:0] junk);
        return {on, req, junk, rs, d};
    endfunction

    initial begin
        int n;
        logic [31:0] v;
        logic [7:0] d;
        logic rs;

        i_reset   = 1'b1;
        i_lcd_reg = 32'd0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(o_lcd_status[0]), 32'd1);
        chk("rst_en", 32'(o_lcd_en), 32'd0);
        chk("rst_status", o_lcd_status & ~32'd1, 32'd0);
        chk("rst_pins", {o_lcd_data, o_lcd_rs, o_lcd_rw, o_lcd_on}, 32'd0);
        i_reset = 1'b0;
        check_init();

        // First write also scrambles the data bits while EN is high.
        req_model = ~req_model;
        v = 32'hC000_0141;
        i_lcd_reg = v;
        follow(v, 1'b1);
        n = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (o_lcd_en || o_lcd_status[0]) n++;
        end
        chk("no_spurious", n, 0);

        req_model = ~req_model;
        v = mk(1'b0, req_model, 1'b0, 8'h01, 21'd0);
        i_lcd_reg = v;
        follow(v, 1'b0);
        req_model = ~req_model;
        v = mk(1'b0, req_model, 1'b0, 8'h80, 21'd0);
        i_lcd_reg = v;
        follow(v, 1'b0);

        for (int k = 0; k < 8; k++) begin
            d  = 8'($urandom_range(0, 255));
            rs = 1'($urandom_range(0, 1));
            if (k % 3 == 0) begin
                d  = 8'($urandom_range(1, 3));
                rs = 1'b0;
            end
            req_model = ~req_model;
            v = mk(1'($urandom_range(0, 1)), req_model, rs, d, 21'($urandom));
            @(negedge clk);
            i_lcd_reg = v;
            follow(v, 1'($urandom_range(0, 1)));
        end

        // Reset while EN is high.
        req_model = ~req_model;
        v = mk(1'b1, req_model, 1'b1, 8'h77, 21'd0);
        @(negedge clk);
        i_lcd_reg = v;
        n = 0;
        while (!o_lcd_en && n < BOUND) begin
            n++;
            @(negedge clk);
        end
        chk("reach_en", 32'(o_lcd_en), 32'd1);
        i_reset   = 1'b1;
        i_lcd_reg = 32'd0;
        req_model = 1'b0;
        @(negedge clk);
        chk("midrst_en", 32'(o_lcd_en), 32'd0);
        chk("midrst_ack", 32'(o_lcd_status[30]), 32'd0);
        chk("midrst_done", 32'(o_lcd_status[1]), 32'd0);
        i_reset = 1'b0;
        check_init();

        // Toggle during the power-on wait: served right after init completes.
        i_reset   = 1'b1;
        i_lcd_reg = 32'd0;
        @(negedge clk);
        i_reset   = 1'b0;
        req_model = ~req_model;
        v = mk(1'b1, req_model, 1'b1, 8'h3C, 21'd0);
        i_lcd_reg = v;
        check_init();
        follow(v, 1'b0);
        chk("pend_ack", 32'(o_lcd_status[30]), 32'(req_model));

        chk("rw_low", 32'(o_lcd_rw), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
